// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared definitions for the MEM-stage data-memory responder:
//   - access size encodings (byte / half / word / illegal)
//   - responder FSM state encoding
//   - helpers for misalignment detection, store byte-lane steering and
//     load-data extraction with sign/zero extension.
// The byte-lane logic assumes a 32-bit data word.
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

  localparam int WORD_BITS = 32;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // An access is an error if it is not naturally aligned or has the
  // reserved size code.
  function automatic logic isMisaligned(input logic [1:0] size,
                                        input logic [1:0] addrLsb);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addrLsb[0];
      SIZE_WORD: return |addrLsb;
      default:   return 1'b1;
    endcase
  endfunction

  // Byte-lane write enables for an aligned store (little-endian lanes).
  function automatic logic [3:0] storeEnables(input logic [1:0] size,
                                              input logic [1:0] addrLsb);
    case (size)
      SIZE_BYTE: return 4'b0001 << addrLsb;
      SIZE_HALF: return addrLsb[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

  // Replicate the low byte/half of the store data across the word so the
  // enabled lanes always see the right bits regardless of offset.
  function automatic logic [WORD_BITS-1:0] storeData(input logic [1:0] size,
                                                     input logic [WORD_BITS-1:0] wdata);
    case (size)
      SIZE_BYTE: return {4{wdata[7:0]}};
      SIZE_HALF: return {2{wdata[15:0]}};
      default:   return wdata;
    endcase
  endfunction

  // Pick the addressed byte/half out of a RAM word and extend it.
  function automatic logic [WORD_BITS-1:0] loadExtend(input logic [1:0]           addrLsb,
                                                      input logic [1:0]           size,
                                                      input logic                 isUnsigned,
                                                      input logic [WORD_BITS-1:0] word);
    logic [WORD_BITS-1:0] byteShift;
    logic [WORD_BITS-1:0] halfShift;
    byteShift = word >> {addrLsb, 3'b000};
    halfShift = word >> {addrLsb[1], 4'b0000};
    case (size)
      SIZE_BYTE: return {{24{byteShift[7] & ~isUnsigned}}, byteShift[7:0]};
      SIZE_HALF: return {{16{halfShift[15] & ~isUnsigned}}, halfShift[15:0]};
      default:   return word;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
// Bundle of the request/response handshake and the debug read port between
// the pipeline MEM stage (master) and the data-memory responder (slave).
//   Request : i_req_valid / o_req_ready, i_req_write, i_req_size,
//             i_req_unsigned, i_addr, i_wdata
//   Response: o_resp_valid / i_resp_ready, o_rdata, o_resp_err
//   Debug   : i_dbg_rd_en, i_dbg_addr -> o_dbg_valid, o_dbg_data
// -----------------------------------------------------------------------------
interface data_mem_responder_if #(
  parameter int N_BITS     = 32,
  parameter int ADDR_WORDS = 10
);

  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_write;
  logic [1:0]            i_req_size;
  logic                  i_req_unsigned;
  logic [N_BITS-1:0]     i_addr;
  logic [N_BITS-1:0]     i_wdata;
  logic                  o_resp_valid;
  logic                  i_resp_ready;
  logic [N_BITS-1:0]     o_rdata;
  logic                  o_resp_err;
  logic                  i_dbg_rd_en;
  logic [ADDR_WORDS-1:0] i_dbg_addr;
  logic                  o_dbg_valid;
  logic [N_BITS-1:0]     o_dbg_data;

  modport master (
    output i_req_valid, i_req_write, i_req_size, i_req_unsigned, i_addr, i_wdata,
    output i_resp_ready, i_dbg_rd_en, i_dbg_addr,
    input  o_req_ready, o_resp_valid, o_rdata, o_resp_err, o_dbg_valid, o_dbg_data
  );

  modport slave (
    input  i_req_valid, i_req_write, i_req_size, i_req_unsigned, i_addr, i_wdata,
    input  i_resp_ready, i_dbg_rd_en, i_dbg_addr,
    output o_req_ready, o_resp_valid, o_rdata, o_resp_err, o_dbg_valid, o_dbg_data
  );

endinterface

// File: rtl/data_mem_responder_ram.sv
// -----------------------------------------------------------------------------
// data_mem_ram
// 2^ADDR_WORDS x 32-bit RAM with per-byte write enables.
//   Port A: synchronous read/write (i_aEn reads, i_aWe byte lanes write).
//   Port B: synchronous read-only (debug).
// Both read ports are read-first: a read of a word written on the same edge
// returns the old contents.
// Ports: i_clk, i_aEn, i_aWe[3:0], i_aAddr, i_aWdata, o_aRdata,
//        i_bEn, i_bAddr, o_bRdata.
// -----------------------------------------------------------------------------
module data_mem_ram #(
  parameter int N_BITS     = 32,
  parameter int ADDR_WORDS = 10
) (
  input  logic                  i_clk,
  input  logic                  i_aEn,
  input  logic [3:0]            i_aWe,
  input  logic [ADDR_WORDS-1:0] i_aAddr,
  input  logic [N_BITS-1:0]     i_aWdata,
  output logic [N_BITS-1:0]     o_aRdata,
  input  logic                  i_bEn,
  input  logic [ADDR_WORDS-1:0] i_bAddr,
  output logic [N_BITS-1:0]     o_bRdata
);

  logic [N_BITS-1:0] mem [2**ADDR_WORDS];

  // NOTE: the storage array has no reset so it maps onto block RAM; its
  // contents deliberately survive a reset of the responder.
  always_ff @(posedge i_clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (i_aWe[lane]) begin
        mem[i_aAddr][lane*8 +: 8] <= i_aWdata[lane*8 +: 8];
      end
    end
    if (i_aEn) begin
      o_aRdata <= mem[i_aAddr];
    end
    if (i_bEn) begin
      o_bRdata <= mem[i_bAddr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Responder end of the MEM-stage data-memory interface. Accepts one load or
// store per request/response pair, writes stores on the accepting edge and
// returns extended load data one cycle later. An independent debug port reads
// raw RAM words at any time.
// Ports:
//   i_clk   - clock, rising edge
//   i_reset - asynchronous, active-high reset
//   bus     - data_mem_responder_if.slave (request, response, debug signals)
// -----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int N_BITS     = 32,
  parameter int ADDR_WORDS = 10
) (
  input logic                  i_clk,
  input logic                  i_reset,
  data_mem_responder_if.slave  bus
);

  state_t state;
  state_t stateNext;

  logic                  accept;
  logic                  reqMisaligned;
  logic [ADDR_WORDS-1:0] wordIdx;
  logic [3:0]            ramWe;
  logic                  ramRdEn;
  logic [N_BITS-1:0]     ramRdata;
  logic [N_BITS-1:0]     ramDbgData;

  // Attributes of the accepted access, held for the whole RESP state.
  logic       respErr;
  logic       respIsLoad;
  logic [1:0] respLsb;
  logic [1:0] respSize;
  logic       respUnsigned;
  logic       dbgValid;

  assign accept        = bus.i_req_valid && bus.o_req_ready;
  assign reqMisaligned = isMisaligned(bus.i_req_size, bus.i_addr[1:0]);
  // Upper address bits are dropped, so addresses alias modulo the RAM size.
  assign wordIdx       = bus.i_addr[ADDR_WORDS+1:2];
  assign ramWe         = (accept && bus.i_req_write && !reqMisaligned)
                         ? storeEnables(bus.i_req_size, bus.i_addr[1:0]) : 4'b0000;
  // The RAM read register is only loaded on a load accept, so it holds the
  // fetched word stable for as long as the response is back-pressured.
  assign ramRdEn       = accept && !bus.i_req_write;

  data_mem_ram #(
    .N_BITS     (N_BITS),
    .ADDR_WORDS (ADDR_WORDS)
  ) u_ram (
    .i_clk    (i_clk),
    .i_aEn    (ramRdEn),
    .i_aWe    (ramWe),
    .i_aAddr  (wordIdx),
    .i_aWdata (storeData(bus.i_req_size, bus.i_wdata)),
    .o_aRdata (ramRdata),
    .i_bEn    (bus.i_dbg_rd_en),
    .i_bAddr  (bus.i_dbg_addr),
    .o_bRdata (ramDbgData)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps every path assigned, so no
  // latch is inferred.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept)           stateNext = RESP;
      RESP: if (bus.i_resp_ready) stateNext = IDLE;
      default:                    stateNext = IDLE;
    endcase
  end

  // Access attributes captured on accept, plus the debug valid flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      respErr      <= 1'b0;
      respIsLoad   <= 1'b0;
      respLsb      <= 2'b00;
      respSize     <= SIZE_BYTE;
      respUnsigned <= 1'b0;
      dbgValid     <= 1'b0;
    end else begin
      if (accept) begin
        respErr      <= reqMisaligned;
        respIsLoad   <= !bus.i_req_write;
        respLsb      <= bus.i_addr[1:0];
        respSize     <= bus.i_req_size;
        respUnsigned <= bus.i_req_unsigned;
      end
      dbgValid <= bus.i_dbg_rd_en;
    end
  end

  // Outputs. Response data is forced to zero outside RESP, for stores and for
  // errors; the debug word is zero unless a debug read just completed.
  always_comb begin
    bus.o_req_ready  = (state == IDLE);
    bus.o_resp_valid = (state == RESP);
    bus.o_resp_err   = (state == RESP) && respErr;
    bus.o_rdata      = '0;
    if ((state == RESP) && respIsLoad && !respErr) begin
      bus.o_rdata = loadExtend(respLsb, respSize, respUnsigned, ramRdata);
    end
    bus.o_dbg_valid = dbgValid;
    bus.o_dbg_data  = dbgValid ? ramDbgData : '0;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed test-plan sequences followed by randomized accesses, all compared
// against a byte-addressed reference memory kept in the bench.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int N_BITS     = 32;
  localparam int ADDR_WORDS = 10;
  localparam int MEM_BYTES  = 4 << ADDR_WORDS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if #(.N_BITS(N_BITS), .ADDR_WORDS(ADDR_WORDS)) bus ();

  data_mem_responder #(.N_BITS(N_BITS), .ADDR_WORDS(ADDR_WORDS)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] refMem [MEM_BYTES];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // ---------------- reference model (byte-addressed memory) ----------------
  function automatic logic refErr(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
    if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] refLoad(input logic [1:0] size, input logic uns, input logic [31:0] addr);
    int base;
    int val;
    if (refErr(size, addr)) return 32'h0;
    base = int'(addr % MEM_BYTES);
    if (size == 2'd0) begin
      val = int'(refMem[base]);
      if (!uns && val >= 128) val -= 256;
      return 32'(val);
    end
    if (size == 2'd1) begin
      val = int'(refMem[base]) + 256 * int'(refMem[base+1]);
      if (!uns && val >= 32768) val -= 65536;
      return 32'(val);
    end
    return {refMem[base+3], refMem[base+2], refMem[base+1], refMem[base]};
  endfunction

  task automatic refStore(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    int base;
    logic [31:0] shifted;
    if (refErr(size, addr)) return;
    base = int'(addr % MEM_BYTES);
    for (int i = 0; i < (1 << size); i++) begin
      shifted = wdata >> (8 * i);
      refMem[base+i] = shifted[7:0];
    end
  endtask

  function automatic logic [31:0] refWord(input int wordIdx);
    return refLoad(2'd2, 1'b0, 32'(wordIdx * 4));
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic driveReq(input logic write, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus.i_req_valid    = 1'b1;
    bus.i_req_write    = write;
    bus.i_req_size     = size;
    bus.i_req_unsigned = uns;
    bus.i_addr         = addr;
    bus.i_wdata        = wdata;
  endtask

  // One complete transaction: accept, optional back-pressure, completion.
  task automatic access(input logic write, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        input string tag, output logic [31:0] gotData, output logic gotErr);
    logic [31:0] expData;
    logic        expErr;
    int          waited;
    expErr  = refErr(size, addr);
    expData = (write || expErr) ? 32'h0 : refLoad(size, uns, addr);
    waited = 0;
    while (!bus.o_req_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, " req_ready"}, 32'(bus.o_req_ready), 32'd1);
    driveReq(write, size, uns, addr, wdata);
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    if (write) refStore(size, addr, wdata);
    check({tag, " resp_valid"}, 32'(bus.o_resp_valid), 32'd1);
    check({tag, " busy"}, 32'(bus.o_req_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, " held valid"}, 32'(bus.o_resp_valid), 32'd1);
      check({tag, " held rdata"}, bus.o_rdata, expData);
      check({tag, " held busy"}, 32'(bus.o_req_ready), 32'd0);
    end
    gotData = bus.o_rdata;
    gotErr  = bus.o_resp_err;
    check({tag, " rdata"}, gotData, expData);
    check({tag, " err"}, 32'(gotErr), 32'(expErr));
    bus.i_resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_resp_ready = 1'b0;
    check({tag, " done"}, 32'(bus.o_resp_valid), 32'd0);
  endtask

  task automatic dbgRead(input int wordIdx, input string tag);
    bus.i_dbg_rd_en = 1'b1;
    bus.i_dbg_addr  = ADDR_WORDS'(wordIdx);
    @(posedge clk); #1;
    bus.i_dbg_rd_en = 1'b0;
    check({tag, " dbg_valid"}, 32'(bus.o_dbg_valid), 32'd1);
    check({tag, " dbg_data"}, bus.o_dbg_data, refWord(wordIdx));
    @(posedge clk); #1;
    check({tag, " dbg_valid off"}, 32'(bus.o_dbg_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic [1:0]  rSize;
    logic [31:0] rAddr;

    rst = 1'b1;
    bus.i_req_valid = 1'b0; bus.i_req_write = 1'b0; bus.i_req_size = 2'd0;
    bus.i_req_unsigned = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
    bus.i_resp_ready = 1'b0; bus.i_dbg_rd_en = 1'b0; bus.i_dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", 32'(bus.o_req_ready), 32'd1);
    check("reset resp_valid", 32'(bus.o_resp_valid), 32'd0);
    check("reset rdata", bus.o_rdata, 32'h0);
    check("reset err", 32'(bus.o_resp_err), 32'd0);
    check("reset dbg_valid", 32'(bus.o_dbg_valid), 32'd0);
    check("reset dbg_data", bus.o_dbg_data, 32'h0);
    rst = 1'b0;

    // Fill the 64-byte test window so every later read has a known value.
    for (int w = 0; w < 16; w++) access(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 0, "init", d, e);

    access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, "SW 10", d, e);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "LW 10", d, e);
    check("LW 10 value", d, 32'hDEADBEEF);
    access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, "LB 13", d, e);
    check("LB 13 value", d, 32'hFFFFFFDE);
    access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, "LBU 13", d, e);
    check("LBU 13 value", d, 32'h000000DE);
    access(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 0, "LH 10", d, e);
    check("LH 10 value", d, 32'hFFFFBEEF);
    access(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, "LHU 12", d, e);
    check("LHU 12 value", d, 32'h0000DEAD);
    access(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000012, 0, "SB 11", d, e);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "LW after SB", d, e);
    check("LW after SB value", d, 32'hDEAD12EF);
    access(1'b1, 2'd1, 1'b0, 32'h12, 32'h00005678, 0, "SH 12", d, e);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "LW after SH", d, e);
    check("LW after SH value", d, 32'h567812EF);

    // Misalignment and illegal size.
    access(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 0, "LW 12 misaligned", d, e);
    check("LW 12 err flag", 32'(e), 32'd1);
    access(1'b1, 2'd1, 1'b0, 32'h11, 32'h0000FFFF, 0, "SH 11 misaligned", d, e);
    check("SH 11 err flag", 32'(e), 32'd1);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, "LW after bad SH", d, e);
    check("LW after bad SH value", d, 32'h567812EF);
    access(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0, "size 11 load", d, e);
    check("size 11 err flag", 32'(e), 32'd1);
    access(1'b1, 2'd3, 1'b0, 32'h14, 32'h0, 0, "size 11 store", d, e);

    // Back-pressure for three cycles.
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3, "LW held", d, e);

    // A request waiting during RESP is not taken on the completing edge.
    driveReq(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    @(posedge clk); #1;
    check("b2b first valid", 32'(bus.o_resp_valid), 32'd1);
    bus.i_addr = 32'h14;
    bus.i_resp_ready = 1'b1;
    @(posedge clk); #1;
    check("b2b gap valid", 32'(bus.o_resp_valid), 32'd0);
    check("b2b gap ready", 32'(bus.o_req_ready), 32'd1);
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    check("b2b second valid", 32'(bus.o_resp_valid), 32'd1);
    check("b2b second rdata", bus.o_rdata, refLoad(2'd2, 1'b0, 32'h14));
    @(posedge clk); #1;
    bus.i_resp_ready = 1'b0;
    check("b2b second done", 32'(bus.o_resp_valid), 32'd0);

    // Reset during RESP drops the response but keeps the committed store.
    driveReq(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D);
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    refStore(2'd2, 32'h20, 32'hCAFEF00D);
    check("rst-resp valid before", 32'(bus.o_resp_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst-resp valid dropped", 32'(bus.o_resp_valid), 32'd0);
    check("rst-resp ready", 32'(bus.o_req_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, "LW after rst", d, e);
    check("LW after rst value", d, 32'hCAFEF00D);

    // Debug read concurrent with a pipeline load.
    driveReq(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    bus.i_dbg_rd_en = 1'b1;
    bus.i_dbg_addr  = ADDR_WORDS'(4);
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    bus.i_dbg_rd_en = 1'b0;
    check("dbg concurrent valid", 32'(bus.o_dbg_valid), 32'd1);
    check("dbg concurrent data", bus.o_dbg_data, 32'h567812EF);
    check("dbg concurrent LW", bus.o_rdata, refLoad(2'd2, 1'b0, 32'h14));
    bus.i_resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_resp_ready = 1'b0;
    check("dbg concurrent off", 32'(bus.o_dbg_valid), 32'd0);

    // Debug read on the same edge as a store to that word sees old data.
    driveReq(1'b1, 2'd2, 1'b0, 32'h10, 32'h11112222);
    bus.i_dbg_rd_en = 1'b1;
    bus.i_dbg_addr  = ADDR_WORDS'(4);
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    bus.i_dbg_rd_en = 1'b0;
    check("dbg old data", bus.o_dbg_data, 32'h567812EF);
    refStore(2'd2, 32'h10, 32'h11112222);
    bus.i_resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_resp_ready = 1'b0;
    dbgRead(4, "dbg new data");

    // Address aliasing modulo RAM size.
    access(1'b0, 2'd2, 1'b0, 32'h1010, 32'h0, 0, "LW alias 1010", d, e);
    check("LW alias value", d, 32'h11112222);
    access(1'b1, 2'd2, 1'b0, 32'h2014, 32'hA5A55A5A, 0, "SW alias 2014", d, e);
    access(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0, "LW 14 after alias", d, e);
    check("alias store value", d, 32'hA5A55A5A);

    // Randomized accesses in the 64-byte window with random aliasing bits.
    for (int i = 0; i < 200; i++) begin
      rSize = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rAddr = {$urandom_range(0, 255) == 0 ? 26'($urandom) : 26'd0, 6'($urandom)};
      access(1'($urandom), rSize, 1'($urandom), rAddr, $urandom,
             $urandom_range(0, 2), "rand", d, e);
      if (i % 10 == 0) dbgRead($urandom_range(0, 15), "rand dbg");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
